// File: rtl/mux_nx1_arb_if.sv
// mux_nx1_arb_if: N-channel mux bus (inputs, select, registered output).
// master drives channels/select/out_ready; slave is the mux side.
interface mux_nx1_arb_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        control;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, mode, control, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, control, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_nx1_arb.sv
// mux_nx1_arb: N-to-1 mux, directed or round-robin, registered output.
// Ports: clk, rst_n (async low), bus (mux_nx1_arb_if.slave).
// Bus: in_data/in_valid/in_ready per channel, mode (1=rr), control,
//   out_data/out_src/out_valid/out_ready.
// Option: MUX_SKID_EN adds a 1-entry skid reg; in_ready then
//   no longer depends on out_ready.
module mux_nx1_arb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_nx1_arb_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic              out_vld_q, out_vld_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef MUX_SKID_EN
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_src_q, skid_src_d;
  logic              skid_vld_q, skid_vld_d;
`endif

  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              can_accept;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;
  logic [NUM_IN-1:0] rdy;
  logic [SEL_W-1:0]  rr_nxt;
  int                idx;

`ifdef MUX_SKID_EN
  assign can_accept = !skid_vld_q;
`else
  assign can_accept = !out_vld_q || bus.out_ready;
`endif

  // Grant: control in directed mode, else the first valid channel
  // scanning upward from rr_ptr with wrap at NUM_IN.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (!bus.mode) begin
      gnt     = bus.control;
      gnt_vld = int'({1'b0, bus.control}) < NUM_IN;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'({1'b0, rr_ptr_q}) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (gnt_vld && can_accept) rdy[gnt] = 1'b1;
  end

  assign xfer     = gnt_vld && can_accept && bus.in_valid[gnt];
  assign sel_data = bus.in_data[int'(gnt)*WIDTH +: WIDTH];
  assign rr_nxt   = (gnt == LAST) ? '0 : gnt + 1'b1;

  always_comb begin
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    out_vld_d  = out_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer && bus.mode) rr_ptr_d = rr_nxt;
`ifdef MUX_SKID_EN
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    skid_vld_d  = skid_vld_q;
    if (!out_vld_q || bus.out_ready) begin
      // Skid word is older than anything arriving now, so it goes first.
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        out_src_d  = skid_src_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (xfer) begin
        out_data_d = sel_data;
        out_src_d  = gnt;
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (xfer) begin
      skid_data_d = sel_data;
      skid_src_d  = gnt;
      skid_vld_d  = 1'b1;
    end
`else
    if (xfer) begin
      out_data_d = sel_data;
      out_src_d  = gnt;
      out_vld_d  = 1'b1;
    end else if (bus.out_ready) begin
      out_vld_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_vld_q   <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef MUX_SKID_EN
      skid_data_q <= '0;
      skid_src_q  <= '0;
      skid_vld_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_vld_q   <= out_vld_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_SKID_EN
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      skid_vld_q  <= skid_vld_d;
`endif
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_vld_q;
endmodule

// File: tb/tb_mux_nx1_arb.sv
// tb_mux_nx1_arb: directed checks on a 4-channel and a 3-channel mux.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_mux_nx1_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [3:0] stall_vld;

  always #5 clk = ~clk;

  mux_nx1_arb_if #(.WIDTH(32), .NUM_IN(4)) if4 ();
  mux_nx1_arb_if #(.WIDTH(32), .NUM_IN(3)) if3 ();

  mux_nx1_arb #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  mux_nx1_arb #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if4.in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
    if4.in_valid  = '0;
    if4.mode      = 1'b0;
    if4.control   = '0;
    if4.out_ready = 1'b1;
    if3.in_data   = {32'd12, 32'd11, 32'd10};
    if3.in_valid  = '0;
    if3.mode      = 1'b0;
    if3.control   = '0;
    if3.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld", 32'(if4.out_valid), 32'd0);
    chk("rst_data", if4.out_data, 32'd0);
    chk("rst_src", 32'(if4.out_src), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // directed, control 0..3
    if4.in_valid = 4'hf;
    for (int c = 0; c < 4; c++) begin
      if4.control = 2'(c);
      #1 chk("dir_rdy", 32'(if4.in_ready), 32'(1 << c));
      tick();
      chk("dir_data", if4.out_data, 32'(c + 1));
      chk("dir_src", 32'(if4.out_src), 32'(c));
      chk("dir_vld", 32'(if4.out_valid), 32'd1);
    end

    // round-robin, all valid
    if4.mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_rdy", 32'(if4.in_ready), 32'(1 << (k % 4)));
      tick();
      chk("rr_src", 32'(if4.out_src), 32'(k % 4));
      chk("rr_data", if4.out_data, 32'(k % 4 + 1));
    end

    // round-robin, channels 1 and 3, pointer now at 2
    if4.in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      automatic int e = (k == 1) ? 1 : 3;
      #1 chk("rr13_rdy", 32'(if4.in_ready), 32'(1 << e));
      tick();
      chk("rr13_src", 32'(if4.out_src), 32'(e));
    end

    // 3-channel wrap 2 -> 0
    if3.mode = 1'b1;
    if3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr3_rdy", 32'(if3.in_ready), 32'(1 << (k % 3)));
      tick();
      chk("rr3_src", 32'(if3.out_src), 32'(k % 3));
      chk("rr3_data", if3.out_data, 32'(10 + k % 3));
    end

    // out-of-range control on 3-channel mux
    if3.mode = 1'b0;
    if3.control = 2'd3;
    if3.out_ready = 1'b0;
    #1 chk("oor_rdy0", 32'(if3.in_ready), 32'd0);
    tick();
    chk("oor_hold_vld", 32'(if3.out_valid), 32'd1);
    chk("oor_hold_data", if3.out_data, 32'd10);
    if3.out_ready = 1'b1;
    #1 chk("oor_rdy1", 32'(if3.in_ready), 32'd0);
    tick();
    chk("oor_drain_vld", 32'(if3.out_valid), 32'd0);
    chk("oor_drain_data", if3.out_data, 32'd10);

    // stall holding 0xA5
    if4.mode = 1'b0;
    if4.control = 2'd0;
    if4.in_valid = 4'hf;
    if4.in_data = {32'd4, 32'd3, 32'd2, 32'hA5};
    if4.out_ready = 1'b1;
    tick();
    chk("stall_load", if4.out_data, 32'hA5);
`ifdef MUX_SKID_EN
    stall_vld = 4'h0;
`else
    stall_vld = 4'hf;
`endif
    if4.out_ready = 1'b0;
    if4.in_valid = stall_vld;
    for (int i = 0; i < 3; i++) begin
      if4.mode = 1'(i);
      if4.control = 2'(i + 1);
      #1;
`ifndef MUX_SKID_EN
      chk("stall_rdy", 32'(if4.in_ready), 32'd0);
`endif
      tick();
      chk("stall_data", if4.out_data, 32'hA5);
      chk("stall_src", 32'(if4.out_src), 32'd0);
      chk("stall_vld", 32'(if4.out_valid), 32'd1);
    end

    // pop with nothing new
    if4.in_valid = 4'h0;
    if4.mode = 1'b0;
    if4.control = 2'd0;
    if4.out_ready = 1'b1;
    tick();
    chk("pop_vld", 32'(if4.out_valid), 32'd0);
    chk("pop_data", if4.out_data, 32'hA5);

    // reset mid-stream
    if4.in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    if4.mode = 1'b1;
    if4.in_valid = 4'hf;
    tick();
    tick();
    chk("pre_rst_src", 32'(if4.out_src), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(if4.out_valid), 32'd0);
    chk("mid_rst_data", if4.out_data, 32'd0);
    chk("mid_rst_src", 32'(if4.out_src), 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("post_rst_rdy", 32'(if4.in_ready), 32'd1);
    tick();
    chk("post_rst_src", 32'(if4.out_src), 32'd0);
    chk("post_rst_data", if4.out_data, 32'd1);

`ifdef MUX_SKID_EN
    // two words accepted while stalled, both emerge in order
    if4.in_valid = 4'h0;
    tick();
    if4.mode = 1'b0;
    if4.control = 2'd0;
    if4.out_ready = 1'b0;
    if4.in_data = {32'd4, 32'd3, 32'd2, 32'h11};
    if4.in_valid = 4'h1;
    tick();
    chk("skid_w0", if4.out_data, 32'h11);
    if4.in_data = {32'd4, 32'd3, 32'd2, 32'h22};
    #1 chk("skid_rdy1", 32'(if4.in_ready), 32'd1);
    tick();
    chk("skid_hold", if4.out_data, 32'h11);
    chk("skid_full_rdy", 32'(if4.in_ready), 32'd0);
    if4.in_valid = 4'h0;
    if4.out_ready = 1'b1;
    tick();
    chk("skid_w1", if4.out_data, 32'h22);
    chk("skid_w1_vld", 32'(if4.out_valid), 32'd1);
    tick();
    chk("skid_empty", 32'(if4.out_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
